mem_fill_arbiter: RTL
=====================

MEM_FILL_ARBITER -- requirements
Module: mem_fill_arbiter

Interface
REQ-001 Parameter ADDR_W, 16, byte-address width SHALL apply.
REQ-002 Parameter DATA_W, 16, memory word width SHALL apply.
REQ-003 Parameter WORDS, 8, words per cache block SHALL apply (power of two).
REQ-004 Ports SHALL be exactly:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- ic_miss  in  1  I-cache miss request, held until ic_fill_done
- ic_addr  in  ADDR_W  I-cache miss byte address
- dc_miss  in  1  D-cache miss request, held until dc_fill_done
- dc_addr  in  ADDR_W  D-cache miss byte address
- dc_wr_req  in  1  D-cache write-through request, held until dc_wr_ack
- dc_wr_addr  in  ADDR_W  write byte address
- dc_wr_data  in  DATA_W  write data
- dc_wr_ack  out  1  one-cycle write accept
- mem_en  out  1  memory access strobe
- mem_wr  out  1  memory write (valid with mem_en)
- mem_addr  out  ADDR_W  memory byte address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- mem_rvalid  in  1  mem_rdata valid
- fill_we  out  1  write fill word into selected cache
- fill_sel  out  1  0 = I-cache, 1 = D-cache
- fill_idx  out  3  word index within block
- fill_data  out  DATA_W  fill word
- ic_fill_done  out  1  one-cycle I fill complete
- dc_fill_done  out  1  one-cycle D fill complete
- busy  out  1  state != IDLE

Function
REQ-005 FSM SHALL have states IDLE, WRITE, FILL, COOL.
REQ-006 IDLE priority SHALL be dc_wr_req, then misses; if both misses are pending, the grant SHALL go to the requester not in last_fill (round-robin); a single pending miss SHALL be granted directly.
REQ-007 WRITE SHALL last exactly one cycle: mem_en=1, mem_wr=1, mem_addr=dc_wr_addr, mem_wdata=dc_wr_data, dc_wr_ack=1; next state IDLE.
REQ-008 On a miss grant, base = addr with low log2(WORDS*2) bits cleared SHALL be latched, fill_sel latched, last_fill updated, next state FILL.
REQ-009 FILL SHALL issue WORDS reads in consecutive cycles starting in the first FILL cycle: mem_en=1, mem_wr=0, mem_addr = base + 2*issue_cnt.
REQ-010 Issue counter SHALL stop after WORDS issues; mem_en SHALL be 0 in the remaining FILL cycles.
REQ-011 Each cycle with mem_rvalid=1 in FILL SHALL produce fill_we=1, fill_data=mem_rdata, fill_idx=recv_cnt (combinational pass-through); recv_cnt then increments.
REQ-012 Gaps in mem_rvalid SHALL stall recv_cnt only; the latency is not assumed.
REQ-013 On the WORDS-th valid, the matching done output SHALL pulse in the same cycle as the last fill_we; next state COOL.
REQ-014 COOL SHALL last one cycle and ignore all requests (requester drops its request), then IDLE.
REQ-015 mem_rvalid outside FILL SHALL be ignored; fill_we SHALL be 0 outside FILL.
REQ-016 New requests arriving during WRITE/FILL/COOL SHALL wait; no request SHALL be dropped.
REQ-017 With a 4-cycle memory (first data 4 cycles after first mem_en), a miss sampled in IDLE at cycle 0 SHALL issue at cycles 1-8, fill at cycles 5-12, done at cycle 12, and reach IDLE at cycle 14.

Reset
REQ-018 rst_n low SHALL asynchronously force IDLE, counters 0, base 0, fill_sel 0, last_fill = I-cache, and all outputs 0.
REQ-019 Reset mid-FILL SHALL abandon the fill without a done pulse; mem_rvalid arriving after reset SHALL be ignored.

Structure
REQ-020 Package mem_arb_pkg SHALL hold the state enum, the WORDS/ADDR_W/DATA_W defaults, and the FILL_SEL_I/FILL_SEL_D constants.
REQ-021 Sub-module fill_word_counter (3-bit, enable, clear, terminal flag) SHALL be instantiated twice, for the issue and receive counters.

Verification
REQ-022 Reset: rst_n=0 -> every output 0, busy=0.
REQ-023 ic_miss, ic_addr=0x1234, 4-cycle memory -> mem_addr 0x1230..0x123E at cycles 1-8; fill_sel=0; fill_idx 0..7 at cycles 5-12; ic_fill_done=1 at cycle 12 only.
REQ-024 ic_miss and dc_miss raised together after reset -> D fill first, then I; both raised again -> D first again (last_fill = I).
REQ-025 dc_wr_req (0x0040, 0xBEEF) and dc_miss in the same cycle -> one WRITE cycle with dc_wr_ack=1, mem_wr=1, then the D fill.
REQ-026 mem_rvalid with 2-cycle gaps -> fill_idx still 0..7 in order; done only on the 8th valid.
REQ-027 rst_n pulsed low at FILL cycle 5 -> outputs 0 immediately, no done; stale mem_rvalid ignored; a subsequent ic_miss completes normally.

Source files
------------

// File: rtl/mem_fill_arbiter_pkg.sv
// mem_arb_pkg: shared types and defaults for the cache fill arbiter.
//   arb_state_t   - arbiter FSM states
//   *_DEFAULT     - default ADDR_W / DATA_W / WORDS parameter values
//   FILL_SEL_I/D  - fill target encoding (0 = I-cache, 1 = D-cache)
package mem_arb_pkg;

    localparam int ADDR_W_DEFAULT = 16;
    localparam int DATA_W_DEFAULT = 16;
    localparam int WORDS_DEFAULT  = 8;
    localparam int IDX_W          = 3;

    localparam logic FILL_SEL_I = 1'b0;
    localparam logic FILL_SEL_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        FILL  = 2'd2,
        COOL  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/mem_fill_arbiter_counter.sv
// fill_word_counter: 3-bit word counter for block fills.
//   clk, rst_n - clock, async active-low reset
//   clr        - synchronous clear (wins over en)
//   en         - advance one word; wraps to 0 after LAST
//   cnt        - current word index
//   term       - cnt is the last word of the block
module fill_word_counter
    import mem_arb_pkg::*;
#(
    parameter int LAST = WORDS_DEFAULT - 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [IDX_W-1:0] cnt,
    output logic             term
);

    localparam logic [IDX_W-1:0] LAST_C = IDX_W'(LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= (cnt == LAST_C) ? '0 : cnt + 1'b1;
    end

    assign term = (cnt == LAST_C);

endmodule

// File: rtl/mem_fill_arbiter.sv
// mem_fill_arbiter: shares one memory port between D-cache write-through
// and I/D-cache block fills.
//   ic_miss/ic_addr, dc_miss/dc_addr - held miss requests (until *_fill_done)
//   dc_wr_req/addr/data, dc_wr_ack   - held write request, one-cycle accept
//   mem_*                            - memory strobe/address/data, read return
//   fill_we/sel/idx/data             - fill word write into the selected cache
//   ic_fill_done, dc_fill_done       - one-cycle fill completion
//   busy                             - arbiter not idle
module mem_fill_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int WORDS  = WORDS_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ic_miss,
    input  logic [ADDR_W-1:0] ic_addr,
    input  logic              dc_miss,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic              dc_wr_req,
    input  logic [ADDR_W-1:0] dc_wr_addr,
    input  logic [DATA_W-1:0] dc_wr_data,
    output logic              dc_wr_ack,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvalid,
    output logic              fill_we,
    output logic              fill_sel,
    output logic [IDX_W-1:0]  fill_idx,
    output logic [DATA_W-1:0] fill_data,
    output logic              ic_fill_done,
    output logic              dc_fill_done,
    output logic              busy
);

    // Byte offset bits within a block (WORDS words of 2 bytes each).
    localparam int OFS_W = $clog2(WORDS * 2);
    localparam logic [ADDR_W-1:0] BASE_MASK = ~ADDR_W'((1 << OFS_W) - 1);

    arb_state_t        state;
    logic [ADDR_W-1:0] base;
    logic              sel_q;
    logic              last_fill;
    logic              issue_done;

    logic [IDX_W-1:0]  issue_cnt, recv_cnt;
    logic              issue_last, recv_last;
    logic              grant_miss, grant_sel;
    logic [ADDR_W-1:0] miss_addr;

    wire in_fill  = (state == FILL);
    wire in_write = (state == WRITE);
    wire issue_en = in_fill && !issue_done;
    wire recv_en  = in_fill && mem_rvalid;
    wire start    = (state == IDLE) && !dc_wr_req && grant_miss;

    // Miss arbitration: with both pending, the side not served last wins.
    always_comb begin
        grant_miss = 1'b0;
        grant_sel  = FILL_SEL_I;
        if (ic_miss && dc_miss) begin
            grant_miss = 1'b1;
            grant_sel  = ~last_fill;
        end else if (dc_miss) begin
            grant_miss = 1'b1;
            grant_sel  = FILL_SEL_D;
        end else if (ic_miss) begin
            grant_miss = 1'b1;
            grant_sel  = FILL_SEL_I;
        end
    end

    assign miss_addr = (grant_sel == FILL_SEL_D) ? dc_addr : ic_addr;

    fill_word_counter #(.LAST(WORDS - 1)) u_issue_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start),
        .en    (issue_en),
        .cnt   (issue_cnt),
        .term  (issue_last)
    );

    fill_word_counter #(.LAST(WORDS - 1)) u_recv_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start),
        .en    (recv_en),
        .cnt   (recv_cnt),
        .term  (recv_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            base       <= '0;
            sel_q      <= FILL_SEL_I;
            last_fill  <= FILL_SEL_I;
            issue_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (dc_wr_req) begin
                        state <= WRITE;
                    end else if (grant_miss) begin
                        state      <= FILL;
                        base       <= miss_addr & BASE_MASK;
                        sel_q      <= grant_sel;
                        last_fill  <= grant_sel;
                        issue_done <= 1'b0;
                    end
                end
                WRITE: state <= IDLE;
                FILL: begin
                    // The 3-bit issue counter wraps, so a flag marks the block as issued.
                    if (issue_en && issue_last)
                        issue_done <= 1'b1;
                    if (recv_en && recv_last)
                        state <= COOL;
                end
                COOL:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign dc_wr_ack = in_write;
    assign mem_en    = in_write || issue_en;
    assign mem_wr    = in_write;
    assign mem_addr  = in_write ? dc_wr_addr :
                       issue_en ? base + ADDR_W'({issue_cnt, 1'b0}) : '0;
    assign mem_wdata = in_write ? dc_wr_data : '0;

    assign fill_we      = recv_en;
    assign fill_sel     = sel_q;
    assign fill_idx     = recv_cnt;
    assign fill_data    = recv_en ? mem_rdata : '0;
    assign ic_fill_done = recv_en && recv_last && (sel_q == FILL_SEL_I);
    assign dc_fill_done = recv_en && recv_last && (sel_q == FILL_SEL_D);
    assign busy         = (state != IDLE);

endmodule
